// File: rtl/logic_unit_arbiter_16_pkg.sv
// Shared constants for the two-requester logic-unit arbiter: opcodes and widths.
// No logic; imported by the arbiter and its datapath.
package logic_unit_arbiter_16_pkg;

  localparam int W_DEFAULT = 16;
  localparam int ID_W      = 1;

  typedef logic [1:0] op_t;

  localparam op_t OP_AND  = 2'b00;
  localparam op_t OP_NAND = 2'b01;
  localparam op_t OP_OR   = 2'b10;
  localparam op_t OP_XOR  = 2'b11;

endpackage

// File: rtl/logic_unit_arbiter_16_bitwise_unit.sv
// Combinational W-bit AND/NAND/OR/XOR built only from 2-input NAND terms.
// Zero latency; no flow control.
module bitwise_unit_16
  import logic_unit_arbiter_16_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  op_t          op,
  output logic [W-1:0] y
);

  logic [W-1:0] n_ab;
  logic [W-1:0] n_aa;
  logic [W-1:0] n_bb;
  logic [W-1:0] and_y;
  logic [W-1:0] or_y;
  logic [W-1:0] xor_y;
  logic [W-1:0] x_l;
  logic [W-1:0] x_r;

  assign n_ab  = ~(a & b);
  assign n_aa  = ~(a & a);
  assign n_bb  = ~(b & b);
  assign and_y = ~(n_ab & n_ab);
  assign or_y  = ~(n_aa & n_bb);
  // Classic four-NAND XOR sharing the a-NAND-b term.
  assign x_l   = ~(a & n_ab);
  assign x_r   = ~(b & n_ab);
  assign xor_y = ~(x_l & x_r);

  always_comb begin
    y = and_y;
    case (op)
      OP_AND:  y = and_y;
      OP_NAND: y = n_ab;
      OP_OR:   y = or_y;
      OP_XOR:  y = xor_y;
      default: y = and_y;
    endcase
  end

endmodule

// File: rtl/logic_unit_arbiter_16.sv
// Round-robin shares one bitwise unit between two requesters; result registered, one cycle from accept.
// Accepts only when the result slot is empty or draining; resp stalls hold data and block both requesters.
module logic_unit_arbiter_16
  import logic_unit_arbiter_16_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [W-1:0] req_a0,
  input  logic [W-1:0] req_b0,
  input  op_t          req_op0,
  input  logic [W-1:0] req_a1,
  input  logic [W-1:0] req_b1,
  input  op_t          req_op1,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [W-1:0] resp_data,
  output logic         resp_id,
  output logic         resp_zero
);

  logic         last_grant;
  logic         slot_free;
  logic [1:0]   grant;
  logic         sel;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  op_t          op_sel;
  logic [W-1:0] unit_y;

  assign slot_free = !resp_valid || resp_ready;

  // Gating on rst_n keeps req_ready low for the whole reset, not just after the first edge.
  always_comb begin
    grant = 2'b00;
    if (rst_n && slot_free) begin
      case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  assign req_ready = grant;
  assign sel       = grant[1];
  assign op_a      = sel ? req_a1  : req_a0;
  assign op_b      = sel ? req_b1  : req_b0;
  assign op_sel    = sel ? req_op1 : req_op0;

  bitwise_unit_16 #(.W(W)) u_unit (
    .a  (op_a),
    .b  (op_b),
    .op (op_sel),
    .y  (unit_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= 1'b0;
      resp_zero  <= 1'b0;
      last_grant <= 1'b1;
    end else if (grant != 2'b00) begin
      resp_valid <= 1'b1;
      resp_data  <= unit_y;
      resp_id    <= sel;
      resp_zero  <= (unit_y == '0);
      last_grant <= sel;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule
